xnor_8_bit: RTL and testbench

//   Bitwise XNOR unit for the Power ALU logic datapath: out[i] = ~(a[i] ^ b[i]).

---
 rtl/xnor_8_bit.sv | 76 +++++++
 tb/tb_xnor_8_bit.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/xnor_8_bit.sv
// Bitwise XNOR unit for the ALU logic datapath.
// Produces a live combinational XNOR of the operands and a one-cycle
// registered copy with a valid strobe, equal/zero flags and a match count.
module xnor_8_bit #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] out_comb,
    output logic [WIDTH-1:0] out,
    output logic             out_valid,
    output logic             eq,
    output logic             zero,
    output logic [CNT_W-1:0] match_cnt
);

    // Number of set bits in v, i.e. the count of operand bit positions that agree.
    function automatic logic [CNT_W-1:0] popcount(input logic [WIDTH-1:0] v);
        logic [CNT_W-1:0] c;
        c = '0;
        for (int i = 0; i < WIDTH; i++) begin
            c = c + CNT_W'(v[i]);
        end
        return c;
    endfunction

    // ---- stage p0: combinational XNOR and status from the live operands ----
    logic [WIDTH-1:0] res_p0;
    logic             eq_p0;
    logic             zero_p0;
    logic [CNT_W-1:0] cnt_p0;

    assign res_p0   = ~(a ^ b);
    assign eq_p0    = &res_p0;
    assign zero_p0  = ~|res_p0;
    assign cnt_p0   = popcount(res_p0);
    assign out_comb = res_p0;

    // ---- stage p1: registered result, loaded only on accepted operands ----
    logic [WIDTH-1:0] res_p1;
    logic             eq_p1;
    logic             zero_p1;
    logic [CNT_W-1:0] cnt_p1;
    logic             vld_p1;

    // Capture result and flags on in_valid; valid strobes for exactly one cycle.
    // Reset clears the result too so no undefined value reaches the result mux.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_p1  <= '0;
            eq_p1   <= 1'b0;
            zero_p1 <= 1'b0;
            cnt_p1  <= '0;
            vld_p1  <= 1'b0;
        end else begin
            vld_p1 <= in_valid;
            if (in_valid) begin
                res_p1  <= res_p0;
                eq_p1   <= eq_p0;
                zero_p1 <= zero_p0;
                cnt_p1  <= cnt_p0;
            end
        end
    end

    assign out       = res_p1;
    assign out_valid = vld_p1;
    assign eq        = eq_p1;
    assign zero      = zero_p1;
    assign match_cnt = cnt_p1;

endmodule

// File: tb/tb_xnor_8_bit.sv
// Testbench for xnor_8_bit: table vectors, hand-written corner sequences and
// randomized traffic against a behavioural model of the XNOR unit.
module tb_xnor_8_bit;

    localparam int WIDTH = 8;
    localparam int CNT_W = 4;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] out_comb;
    logic [WIDTH-1:0] out;
    logic             out_valid;
    logic             eq;
    logic             zero;
    logic [CNT_W-1:0] match_cnt;

    int checks   = 0;
    int failures = 0;

    // reference model state (what the registered outputs should show)
    logic [WIDTH-1:0] m_out;
    logic             m_vld;
    logic             m_eq;
    logic             m_zero;
    int               m_cnt;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] out;
        int         cnt;
        logic       eq;
        logic       zero;
    } vec_t;

    vec_t vecs[8];

    xnor_8_bit #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .out_comb  (out_comb),
        .out       (out),
        .out_valid (out_valid),
        .eq        (eq),
        .zero      (zero),
        .match_cnt (match_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // bit i is set when a and b agree in position i
    function automatic logic [WIDTH-1:0] ref_xnor(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        logic [WIDTH-1:0] r;
        r = '0;
        for (int i = 0; i < WIDTH; i++) r[i] = (x[i] == y[i]);
        return r;
    endfunction

    function automatic int ref_matches(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        int n;
        n = 0;
        for (int i = 0; i < WIDTH; i++) if (x[i] == y[i]) n++;
        return n;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_regs(input string tag);
        chk({tag, ".out"},       32'(out),       32'(m_out));
        chk({tag, ".out_valid"}, 32'(out_valid), 32'(m_vld));
        chk({tag, ".eq"},        32'(eq),        32'(m_eq));
        chk({tag, ".zero"},      32'(zero),      32'(m_zero));
        chk({tag, ".match_cnt"}, 32'(match_cnt), 32'(m_cnt));
    endtask

    task automatic model_reset();
        m_out  = '0;
        m_vld  = 1'b0;
        m_eq   = 1'b0;
        m_zero = 1'b0;
        m_cnt  = 0;
    endtask

    // Called at a falling edge: drive operands, check the combinational path,
    // let one rising edge pass, then check the registered outputs.
    task automatic step(input logic va, input logic [WIDTH-1:0] va_a, input logic [WIDTH-1:0] va_b);
        in_valid = va;
        a        = va_a;
        b        = va_b;
        #1;
        chk("out_comb", 32'(out_comb), 32'(ref_xnor(va_a, va_b)));
        @(posedge clk);
        m_vld = va;
        if (va) begin
            m_out  = ref_xnor(va_a, va_b);
            m_eq   = (va_a == va_b);
            m_zero = (va_a == ~va_b);
            m_cnt  = ref_matches(va_a, va_b);
        end
        @(negedge clk);
        chk_regs("step");
    endtask

    initial begin
        vecs[0] = '{8'hFF, 8'h4A, 8'h4A, 3, 1'b0, 1'b0};
        vecs[1] = '{8'h00, 8'hFF, 8'h00, 0, 1'b0, 1'b1};
        vecs[2] = '{8'h55, 8'hAA, 8'h00, 0, 1'b0, 1'b1};
        vecs[3] = '{8'h00, 8'h00, 8'hFF, 8, 1'b1, 1'b0};
        vecs[4] = '{8'hFF, 8'h81, 8'h81, 2, 1'b0, 1'b0};
        vecs[5] = '{8'h84, 8'h40, 8'h3B, 5, 1'b0, 1'b0};
        vecs[6] = '{8'h88, 8'h85, 8'hF2, 5, 1'b0, 1'b0};
        vecs[7] = '{8'h90, 8'h97, 8'hF8, 5, 1'b0, 1'b0};

        rst_n    = 1'b0;
        in_valid = 1'b0;
        a        = 8'h3C;
        b        = 8'h0F;
        model_reset();

        // reset state before any clock edge; combinational path live in reset
        #3;
        chk_regs("reset");
        chk("reset.out_comb", 32'(out_comb), 32'(8'hCC));

        @(negedge clk);
        rst_n = 1'b1;

        // table vectors, applied back-to-back
        for (int i = 0; i < 8; i++) begin
            step(1'b1, vecs[i].a, vecs[i].b);
            chk("tbl.out",       32'(out),       32'(vecs[i].out));
            chk("tbl.match_cnt", 32'(match_cnt), 32'(vecs[i].cnt));
            chk("tbl.eq",        32'(eq),        32'(vecs[i].eq));
            chk("tbl.zero",      32'(zero),      32'(vecs[i].zero));
            chk("tbl.out_valid", 32'(out_valid), 32'(1));
        end

        // idle with changing operands: out holds last accepted result
        step(1'b0, 8'h12, 8'h34);
        step(1'b0, 8'hA5, 8'h5A);
        chk("hold.out",       32'(out),       32'(8'hF8));
        chk("hold.out_valid", 32'(out_valid), 32'(0));

        // reset asserted between edges with a pending result
        step(1'b1, 8'h0F, 8'h0F);
        in_valid = 1'b1;
        a        = 8'hC3;
        b        = 8'h3C;
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk_regs("midrst");
        chk("midrst.out_comb", 32'(out_comb), 32'(8'h00));
        @(posedge clk);
        @(negedge clk);
        chk_regs("midrst_hold");
        rst_n = 1'b1;
        step(1'b1, 8'hF0, 8'hF0);
        chk("postrst.eq", 32'(eq), 32'(1));

        // randomized traffic
        for (int n = 0; n < 300; n++) begin
            step(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
